// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of a PWM input in clk cycles.
// Each result, or a stuck-input report, is handed out over a valid/ready handshake.
module pwm_capture #(
   parameter int          CNT_W   = 16,
   parameter int unsigned TIMEOUT = 5000
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] meas_high,
   output logic [CNT_W-1:0] meas_period,
   output logic             meas_timeout,
   output logic             meas_level,
   output logic             meas_overrun,
   output logic             meas_valid,
   input  logic             meas_ready
);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

   state_t           r_state, w_state_next;
   logic             r_sync1, r_sync2, r_prev;
   logic             w_rise, w_fall, w_edge;
   logic [CNT_W-1:0] r_cnt_per, r_cnt_hi, r_cnt_idle;
   logic [CNT_W-1:0] w_per_next, w_hi_next, w_idle_next;
   logic [CNT_W-1:0] w_per_inc, w_hi_inc, w_idle_inc;
   logic             r_stuck, w_stuck_next;
   logic             w_timeout_hit;
   logic             w_pub, w_pub_to;

   logic [CNT_W-1:0] r_meas_high, r_meas_period;
   logic             r_meas_timeout, r_meas_level, r_meas_overrun, r_meas_valid;
   logic             r_drop;

   // Two synchronizer flops plus one history flop for edge detection.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_rise = r_sync2 & ~r_prev;
   assign w_fall = ~r_sync2 & r_prev;
   assign w_edge = w_rise | w_fall;

   assign w_per_inc  = (r_cnt_per  == CNT_MAX) ? r_cnt_per  : r_cnt_per  + ONE;
   assign w_hi_inc   = (r_cnt_hi   == CNT_MAX) ? r_cnt_hi   : r_cnt_hi   + ONE;
   assign w_idle_inc = (r_cnt_idle == CNT_MAX) ? r_cnt_idle : r_cnt_idle + ONE;

   // An edge in the same cycle always wins over the timeout; r_stuck limits
   // each stuck episode to a single report until the next edge re-arms it.
   assign w_timeout_hit = !w_edge && !r_stuck && (r_cnt_idle == TO_VAL);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state    <= S_IDLE;
         r_cnt_per  <= '0;
         r_cnt_hi   <= '0;
         r_cnt_idle <= '0;
         r_stuck    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt_per  <= w_per_next;
         r_cnt_hi   <= w_hi_next;
         r_cnt_idle <= w_idle_next;
         r_stuck    <= w_stuck_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_per_next   = r_cnt_per;
      w_hi_next    = r_cnt_hi;
      w_idle_next  = w_idle_inc;
      w_stuck_next = r_stuck;
      w_pub        = 1'b0;
      w_pub_to     = 1'b0;
      if (!en) begin
         w_state_next = S_IDLE;
         w_per_next   = '0;
         w_hi_next    = '0;
         w_idle_next  = '0;
      end else begin
         if (w_edge) begin
            w_idle_next  = '0;
            w_stuck_next = 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  w_state_next = S_HIGH;
                  w_per_next   = ONE;
                  w_hi_next    = ONE;
               end
            end
            S_HIGH: begin
               w_per_next = w_per_inc;
               if (w_fall) w_state_next = S_LOW;
               else        w_hi_next    = w_hi_inc;
            end
            S_LOW: begin
               if (w_rise) begin
                  w_pub        = 1'b1;
                  w_per_next   = ONE;
                  w_hi_next    = ONE;
                  w_state_next = S_HIGH;
               end else begin
                  w_per_next = w_per_inc;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
         if (w_timeout_hit) begin
            w_pub        = 1'b1;
            w_pub_to     = 1'b1;
            w_stuck_next = 1'b1;
            w_state_next = S_IDLE;
            w_per_next   = '0;
            w_hi_next    = '0;
         end
      end
   end

   // A full result register that is not being consumed this cycle keeps its
   // contents; the newcomer is dropped and remembered in r_drop.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_meas_high    <= '0;
         r_meas_period  <= '0;
         r_meas_timeout <= 1'b0;
         r_meas_level   <= 1'b0;
         r_meas_overrun <= 1'b0;
         r_meas_valid   <= 1'b0;
         r_drop         <= 1'b0;
      end else if (w_pub) begin
         if (!r_meas_valid || meas_ready) begin
            r_meas_high    <= w_pub_to ? '0 : r_cnt_hi;
            r_meas_period  <= w_pub_to ? '0 : r_cnt_per;
            r_meas_timeout <= w_pub_to;
            r_meas_level   <= r_sync2;
            r_meas_overrun <= r_drop;
            r_meas_valid   <= 1'b1;
            r_drop         <= 1'b0;
         end else begin
            r_drop <= 1'b1;
         end
      end else if (r_meas_valid && meas_ready) begin
         r_meas_valid <= 1'b0;
      end
   end

   assign meas_high    = r_meas_high;
   assign meas_period  = r_meas_period;
   assign meas_timeout = r_meas_timeout;
   assign meas_level   = r_meas_level;
   assign meas_overrun = r_meas_overrun;
   assign meas_valid   = r_meas_valid;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives directed and random PWM patterns into pwm_capture and
// checks every cycle against a timestamp-based reference model.
module tb_pwm_capture;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 5000;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             clr_n, en, pwm_in, meas_ready;
   logic [CNT_W-1:0] meas_high, meas_period;
   logic             meas_timeout, meas_level, meas_overrun, meas_valid;

   always #5 clk = ~clk;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .clr_n        (clr_n),
      .en           (en),
      .pwm_in       (pwm_in),
      .meas_high    (meas_high),
      .meas_period  (meas_period),
      .meas_timeout (meas_timeout),
      .meas_level   (meas_level),
      .meas_overrun (meas_overrun),
      .meas_valid   (meas_valid),
      .meas_ready   (meas_ready)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      int hi;
      int per;
      bit to;
      bit lvl;
      bit ovr;
   } res_t;

   res_t acc_q[$];   // every result the consumer accepted, in order

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Edges are located in time by cycle stamps; results are differences of stamps.
   int   m_n = 0;
   bit   m_h0, m_h1, m_h2;          // pwm_in as sampled 1, 2 and 3 edges ago
   int   m_phase;                   // 0 waiting for rise, 1 high, 2 low
   int   m_t_rise, m_t_fall, m_t_edge;
   bit   m_stuck, m_drop;
   bit   m_valid, m_to, m_lvl, m_ovr;
   int   m_hi, m_per;
   bit   mv_sync, mv_rise, mv_fall, mv_pub, mv_pto;
   int   mv_phi, mv_pper;

   function automatic int sat(int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   always @(posedge clk) begin
      m_n++;
      if (clr_n && meas_valid && meas_ready)
         acc_q.push_back('{hi: int'(meas_high), per: int'(meas_period),
                           to: meas_timeout, lvl: meas_level, ovr: meas_overrun});
      if (!clr_n) begin
         {m_h0, m_h1, m_h2} = 3'b000;
         m_phase = 0; m_t_edge = m_n; m_stuck = 1'b0; m_drop = 1'b0;
         m_valid = 1'b0; m_to = 1'b0; m_lvl = 1'b0; m_ovr = 1'b0;
         m_hi = 0; m_per = 0;
      end else begin
         mv_sync = m_h1;
         mv_rise = m_h1 && !m_h2;
         mv_fall = !m_h1 && m_h2;
         mv_pub  = 1'b0;
         mv_pto  = 1'b0;
         mv_phi  = 0;
         mv_pper = 0;
         if (en) begin
            if (m_phase == 0 && mv_rise) begin
               m_phase = 1; m_t_rise = m_n;
            end else if (m_phase == 1 && mv_fall) begin
               m_phase = 2; m_t_fall = m_n;
            end else if (m_phase == 2 && mv_rise) begin
               mv_pub = 1'b1;
               mv_phi = sat(m_t_fall - m_t_rise);
               mv_pper = sat(m_n - m_t_rise);
               m_t_rise = m_n; m_phase = 1;
            end
            if (!(mv_rise || mv_fall) && !m_stuck && (m_n - 1 - m_t_edge) == TIMEOUT) begin
               mv_pub = 1'b1; mv_pto = 1'b1; m_phase = 0; m_stuck = 1'b1;
            end
            if (mv_rise || mv_fall) begin
               m_t_edge = m_n; m_stuck = 1'b0;
            end
         end else begin
            m_phase = 0; m_t_edge = m_n;
         end
         if (mv_pub) begin
            if (!m_valid || meas_ready) begin
               m_hi = mv_phi; m_per = mv_pper; m_to = mv_pto; m_lvl = mv_sync;
               m_ovr = m_drop; m_drop = 1'b0; m_valid = 1'b1;
            end else begin
               m_drop = 1'b1;
            end
         end else if (m_valid && meas_ready) begin
            m_valid = 1'b0;
         end
         m_h2 = m_h1; m_h1 = m_h0; m_h0 = pwm_in;
      end
   end

   // One compare per cycle: valid always, result fields whenever valid is set.
   always @(posedge clk) begin
      #1;
      tests++;
      if (meas_valid !== m_valid ||
          (m_valid && (int'(meas_high) != m_hi || int'(meas_period) != m_per ||
                       meas_timeout !== m_to || meas_level !== m_lvl ||
                       meas_overrun !== m_ovr))) begin
         fails++;
         $display("FAIL cycle_cmp t=%0t: got v=%0b hi=%0d per=%0d to=%0b lvl=%0b ovr=%0b, expected v=%0b hi=%0d per=%0d to=%0b lvl=%0b ovr=%0b",
                  $time, meas_valid, meas_high, meas_period, meas_timeout, meas_level, meas_overrun,
                  m_valid, m_hi, m_per, m_to, m_lvl, m_ovr);
      end
   end

   // ---------------- helpers ----------------
   task automatic cyc(int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic pwm_per(int hi, int lo);
      pwm_in = 1'b1; cyc(hi);
      pwm_in = 1'b0; cyc(lo);
   endtask

   task automatic rand_phase(bit lvl, int len);
      pwm_in = lvl;
      for (int i = 0; i < len; i++) begin
         meas_ready = ($urandom_range(0, 3) != 0);
         en         = ($urandom_range(0, 249) != 0);
         @(negedge clk);
      end
   endtask

   function automatic int count_res(int from, int hi, int per, bit tmo);
      int c = 0;
      for (int i = from; i < acc_q.size(); i++)
         if (acc_q[i].hi == hi && acc_q[i].per == per && acc_q[i].to == tmo) c++;
      return c;
   endfunction

   function automatic res_t get_res(int idx);
      res_t r = '{hi: -1, per: -1, to: 1'b0, lvl: 1'b0, ovr: 1'b0};
      if (idx >= 0 && idx < acc_q.size()) r = acc_q[idx];
      return r;
   endfunction

   function automatic int find_to(int from);
      for (int i = from; i < acc_q.size(); i++)
         if (acc_q[i].to) return i;
      return -1;
   endfunction

   task automatic check_zero(string tag);
      check({tag, "_valid"},   int'(meas_valid),   0);
      check({tag, "_high"},    int'(meas_high),    0);
      check({tag, "_period"},  int'(meas_period),  0);
      check({tag, "_timeout"}, int'(meas_timeout), 0);
      check({tag, "_level"},   int'(meas_level),   0);
      check({tag, "_overrun"}, int'(meas_overrun), 0);
   endtask

   // ---------------- stimulus ----------------
   int   w;
   res_t r;

   initial begin
      clr_n = 1'b0; en = 1'b1; pwm_in = 1'b0; meas_ready = 1'b1;
      cyc(3);
      check_zero("reset");
      clr_n = 1'b1;
      cyc(5);

      // Steady 450/50: first rise only starts a measurement.
      w = acc_q.size();
      repeat (6) pwm_per(450, 50);
      check("steady_count", acc_q.size() - w, 5);
      check("steady_450_500", count_res(w, 450, 500, 1'b0), 5);
      check("steady_overrun", get_res(w + 4).ovr, 0);

      // Duty change; first rise here closes the last steady period.
      w = acc_q.size();
      repeat (4) pwm_per(250, 250);
      repeat (4) pwm_per(50, 450);
      check("duty_count", acc_q.size() - w, 8);
      check("duty_450_500", count_res(w, 450, 500, 1'b0), 1);
      check("duty_250_500", count_res(w, 250, 500, 1'b0), 4);
      check("duty_50_500", count_res(w, 50, 500, 1'b0), 3);

      // Backpressure for three periods.
      w = acc_q.size();
      meas_ready = 1'b0;
      repeat (3) pwm_per(100, 100);
      meas_ready = 1'b1;
      repeat (3) pwm_per(100, 100);
      check("bp_count", acc_q.size() - w, 4);
      r = get_res(w);
      check("bp_held_high", r.hi, 50);
      check("bp_held_period", r.per, 500);
      check("bp_held_overrun", r.ovr, 0);
      r = get_res(w + 1);
      check("bp_next_high", r.hi, 100);
      check("bp_next_overrun", r.ovr, 1);
      check("bp_after_overrun", get_res(w + 2).ovr, 0);

      // Accept and publish in the same cycle.
      w = acc_q.size();
      pwm_in = 1'b1; cyc(8);
      meas_ready = 1'b0; cyc(142);
      pwm_in = 1'b0; cyc(150);
      pwm_in = 1'b1; cyc(150);
      pwm_in = 1'b0; cyc(150);
      pwm_in = 1'b1; cyc(2);           // rise is acted on at the coming edge
      meas_ready = 1'b1; cyc(1);
      meas_ready = 1'b0;
      check("simul_valid", int'(meas_valid), 1);
      check("simul_overrun", int'(meas_overrun), 0);
      check("simul_high", int'(meas_high), 150);
      check("simul_period", int'(meas_period), 300);
      check("simul_accepted", acc_q.size() - w, 2);
      cyc(147);
      pwm_in = 1'b0; meas_ready = 1'b1; cyc(150);

      // Stuck high, then resume.
      w = acc_q.size();
      pwm_in = 1'b1; cyc(12000);
      pwm_in = 1'b0; cyc(100);
      pwm_per(100, 100);
      pwm_per(100, 100);
      check("stuck_count", acc_q.size() - w, 3);
      check("stuck_to_count", count_res(w, 0, 0, 1'b1), 1);
      r = get_res(find_to(w));
      check("stuck_level", r.lvl, 1);
      check("stuck_high", r.hi, 0);
      check("resume_100_200", count_res(w, 100, 200, 1'b0), 1);

      // Stuck low.
      w = acc_q.size();
      cyc(6000);
      check("low_count", acc_q.size() - w, 1);
      r = get_res(w);
      check("low_timeout", r.to, 1);
      check("low_level", r.lvl, 0);

      // Reset while high with a held result.
      meas_ready = 1'b0;
      pwm_per(100, 100);
      pwm_in = 1'b1; cyc(50);
      check("pre_reset_valid", int'(meas_valid), 1);
      clr_n = 1'b0;
      #1;
      check_zero("midrst");
      cyc(5);
      clr_n = 1'b1; meas_ready = 1'b1;
      w = acc_q.size();
      cyc(50);
      pwm_in = 1'b0; cyc(100);
      check("rst_no_spurious", acc_q.size() - w, 0);
      check("rst_no_valid", int'(meas_valid), 0);
      pwm_per(100, 100);

      // Enable dropped mid-period.
      pwm_in = 1'b1; cyc(50);
      en = 1'b0;
      w = acc_q.size();
      cyc(100);
      en = 1'b1; cyc(50);
      pwm_in = 1'b0; cyc(200);
      pwm_per(200, 200);
      check("en_no_result", acc_q.size() - w, 0);
      pwm_in = 1'b1; cyc(10);
      check("en_resume_count", acc_q.size() - w, 1);
      r = get_res(w);
      check("en_resume_high", r.hi, 200);
      check("en_resume_period", r.per, 400);

      // Random pulse widths, random ready, occasional enable drops.
      for (int i = 0; i < 60; i++) begin
         rand_phase(1'b1, $urandom_range(1, 40));
         rand_phase(1'b0, $urandom_range(1, 40));
      end
      en = 1'b1; meas_ready = 1'b1;
      cyc(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
